ex_wb_pipe: RTL and testbench
=============================

Name: ex_wb_pipe

Overview:
- Elastic pipeline register between the execute stage and writeback.
- Carries the ALU results, destination register indices, write enables and ALU flags.
- Unlike the decode-side register, it has a valid/ready handshake and a 2-entry skid buffer, so writeback back-pressure stalls execute without dropping data.
- `ready_o` is driven only from a flop, so the stall path does not become a long combinational chain.

Parameters:
- REGI_BITS, 4, width of the scalar destination register index
- VECT_BITS, 2, width of the vector destination register index
- REGI_SIZE, 16, scalar result width
- VECT_SIZE, 8, elements per vector
- ELEM_SIZE, 8, bits per vector element

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- flush_i  in  1  synchronous pipeline flush
- valid_i  in  1  execute presents a result
- ready_o  out  1  this block can accept (registered)
- intRes_i  in  REGI_SIZE  scalar result
- vecRes_i  in  ELEM_SIZE*VECT_SIZE  vector result
- rdInt_i  in  REGI_BITS  scalar destination index
- rdVec_i  in  VECT_BITS  vector destination index
- wrInt_i  in  1  scalar write enable
- wrVec_i  in  1  vector write enable
- alu_flags_i  in  2  ALU flags
- valid_o  out  1  result presented to writeback
- ready_i  in  1  writeback accepts
- intRes_o, vecRes_o, rdInt_o, rdVec_o, wrInt_o, wrVec_o, alu_flags_o  out  same widths as inputs  registered payload

Behaviour:
- Handshake and transfer:
  - Input transfer happens when valid_i && ready_o.
  - Output transfer happens when valid_o && ready_i.
- Storage: a main register (drives the outputs) and a skid register.
- State machine: EMPTY (neither register valid), BUSY (main valid), FULL (main and skid valid).
- Transitions:
  - EMPTY + in-transfer -> BUSY; payload loaded into main.
  - BUSY + in, no out -> FULL; payload loaded into skid.
  - BUSY + out, no in -> EMPTY.
  - BUSY + in + out -> BUSY; main loads the new payload.
  - FULL + out -> BUSY; main loads from skid.
  - FULL: ready_o=0, so no in-transfer is possible.
  - Any other combination holds the current state.
- Outputs:
  - ready_o is registered; it equals 1 exactly when the next state is not FULL.
  - valid_o = (state != EMPTY), driven from a state flop.
- Latency and throughput:
  - 1 cycle from in-transfer to valid_o when EMPTY.
  - Sustained 1 transfer per cycle while ready_i=1.
- Payload stability: while valid_o=1 && ready_i=0, all payload outputs and valid_o hold stable.
- Ordering: strict FIFO order; no reordering, no duplication, no loss.
- wrInt/wrVec gating: wrInt_o and wrVec_o are forced to 0 whenever valid_o=0, so an invalid slot never writes.
- flush_i=1, at the next edge:
  - state -> EMPTY; valid_o=0; ready_o=1.
  - Flush beats a simultaneous in-transfer; that input is discarded.
  - Payload registers may keep stale data, but wr*_o and valid_o are 0.
- Reset (rst_i=0), asynchronous, including mid-transfer:
  - state=EMPTY; valid_o=0; ready_o=1.
  - All payload outputs 0, alu_flags_o=0, wrInt_o=wrVec_o=0.
  - Release is synchronous to clk_i.
- Boundary: ready_i may toggle arbitrarily. valid_i may drop without a transfer; the upstream rule is not checked here.

Optional Feature:
- Macro: EX_WB_PIPE_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt_o[15:0].
  - Counts cycles with valid_o=1 && ready_i=0, saturating at 16'hFFFF.
  - Cleared only by rst_i; flush_i does not clear it.
  - Adds output full_o = (state==FULL), registered.
- Undefined: neither port exists; no counter logic.

Test Plan:
- Reset, then release with valid_i=0 -> valid_o=0, ready_o=1, all outputs 0.
- ready_i=1, valid_i=1 for 4 cycles with intRes_i=1,2,3,4 -> intRes_o=1,2,3,4 on consecutive cycles starting 1 cycle later; ready_o stays 1.
- ready_i=0, send A=16'h00AA then B=16'h00BB -> state FULL, ready_o=0, output holds A. Raise ready_i -> A then B delivered in order; ready_o returns to 1.
- FULL state with flush_i=1 and valid_i=1 same cycle -> next cycle valid_o=0, wrInt_o=0, ready_o=1; the flushed and new payloads never appear.
- Assert rst_i=0 asynchronously mid-stream while FULL -> outputs clear immediately, with no clock edge needed.
- With EX_WB_PIPE_STALL_CNT_EN, hold valid_o=1 and ready_i=0 for 70000 cycles -> stall_cnt_o=16'hFFFF; a flush leaves it unchanged.

Source files
------------

// File: rtl/ex_wb_pipe_if.sv
// Execute-to-writeback handshake bundle: valid/ready plus the result payload.
// The master drives valid and payload; the slave answers with ready.
interface ex_wb_pipe_if #(
    parameter int REGI_BITS = 4,
    parameter int VECT_BITS = 2,
    parameter int REGI_SIZE = 16,
    parameter int VECT_SIZE = 8,
    parameter int ELEM_SIZE = 8
) ();
    logic                           valid;
    logic                           ready;
    logic [REGI_SIZE-1:0]           int_res;
    logic [ELEM_SIZE*VECT_SIZE-1:0] vec_res;
    logic [REGI_BITS-1:0]           rd_int;
    logic [VECT_BITS-1:0]           rd_vec;
    logic                           wr_int;
    logic                           wr_vec;
    logic [1:0]                     alu_flags;

    modport master (
        output valid, int_res, vec_res, rd_int, rd_vec, wr_int, wr_vec, alu_flags,
        input  ready
    );

    modport slave (
        input  valid, int_res, vec_res, rd_int, rd_vec, wr_int, wr_vec, alu_flags,
        output ready
    );
endinterface

// File: rtl/ex_wb_pipe.sv
// Elastic EX->WB pipeline register with a 2-entry skid buffer and a flop-driven ready.
// Optional stall counter and full flag: define EX_WB_PIPE_STALL_CNT_EN.
module ex_wb_pipe #(
    parameter int REGI_BITS = 4,
    parameter int VECT_BITS = 2,
    parameter int REGI_SIZE = 16,
    parameter int VECT_SIZE = 8,
    parameter int ELEM_SIZE = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    ex_wb_pipe_if.slave  in_if,
    ex_wb_pipe_if.master out_if
`ifdef EX_WB_PIPE_STALL_CNT_EN
    ,
    output logic [15:0]  stall_cnt_o,
    output logic         full_o
`endif
);

    typedef struct packed {
        logic [REGI_SIZE-1:0]           int_res;
        logic [ELEM_SIZE*VECT_SIZE-1:0] vec_res;
        logic [REGI_BITS-1:0]           rd_int;
        logic [VECT_BITS-1:0]           rd_vec;
        logic                           wr_int;
        logic                           wr_vec;
        logic [1:0]                     alu_flags;
    } payload_t;

    // Bit 0 of the encoding is "main valid", so valid_o comes straight off a flop.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    state_t   state_q, state_d;
    logic     ready_q, ready_d;
    payload_t main_q,  main_d;
    payload_t skid_q,  skid_d;
    payload_t in_pl;
    logic     in_xfer;
    logic     out_xfer;
    logic     valid;

    assign in_pl = {in_if.int_res, in_if.vec_res, in_if.rd_int, in_if.rd_vec,
                    in_if.wr_int, in_if.wr_vec, in_if.alu_flags};

    assign valid    = state_q[0];
    assign in_xfer  = in_if.valid && ready_q;
    assign out_xfer = valid && out_if.ready;

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    main_d  = in_pl;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (in_xfer && out_xfer) begin
                    main_d = in_pl;
                end else if (in_xfer) begin
                    skid_d  = in_pl;
                    state_d = ST_FULL;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_xfer) begin
                    main_d  = skid_q;
                    state_d = ST_BUSY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Flush wins over any transfer in the same cycle; payload may go stale.
        if (flush_i) begin
            state_d = ST_EMPTY;
        end

        ready_d = (state_d != ST_FULL);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    // NOTE: payload flops are reset too because the outputs must read 0 in reset,
    // not just be marked invalid.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b1;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign in_if.ready      = ready_q;
    assign out_if.valid     = valid;
    assign out_if.int_res   = main_q.int_res;
    assign out_if.vec_res   = main_q.vec_res;
    assign out_if.rd_int    = main_q.rd_int;
    assign out_if.rd_vec    = main_q.rd_vec;
    assign out_if.alu_flags = main_q.alu_flags;
    // An invalid slot must never write the register files.
    assign out_if.wr_int    = main_q.wr_int & valid;
    assign out_if.wr_vec    = main_q.wr_vec & valid;

`ifdef EX_WB_PIPE_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        full_q,      full_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (valid && !out_if.ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        full_d = (state_d == ST_FULL);
    end

    // Only reset clears the counter; flush deliberately leaves it alone.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            full_q      <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            full_q      <= full_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign full_o      = full_q;
`endif

endmodule

// File: tb/tb_ex_wb_pipe.sv
// Directed self-checking bench for ex_wb_pipe: reset, streaming, skid, flush,
// ordering under toggling ready, async reset, and the optional stall counter.
module tb_ex_wb_pipe;

    localparam int REGI_BITS = 4;
    localparam int VECT_BITS = 2;
    localparam int REGI_SIZE = 16;
    localparam int VECT_SIZE = 8;
    localparam int ELEM_SIZE = 8;

    logic clk_i   = 1'b0;
    logic rst_i   = 1'b0;
    logic flush_i = 1'b0;
    int   total   = 0;
    int   bad     = 0;

    always #5 clk_i = ~clk_i;

    ex_wb_pipe_if #(.REGI_BITS(REGI_BITS), .VECT_BITS(VECT_BITS), .REGI_SIZE(REGI_SIZE),
                    .VECT_SIZE(VECT_SIZE), .ELEM_SIZE(ELEM_SIZE)) in_if ();
    ex_wb_pipe_if #(.REGI_BITS(REGI_BITS), .VECT_BITS(VECT_BITS), .REGI_SIZE(REGI_SIZE),
                    .VECT_SIZE(VECT_SIZE), .ELEM_SIZE(ELEM_SIZE)) out_if ();

`ifdef EX_WB_PIPE_STALL_CNT_EN
    logic [15:0] stall_cnt_o;
    logic        full_o;
`endif

    ex_wb_pipe #(.REGI_BITS(REGI_BITS), .VECT_BITS(VECT_BITS), .REGI_SIZE(REGI_SIZE),
                 .VECT_SIZE(VECT_SIZE), .ELEM_SIZE(ELEM_SIZE)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_if       (in_if.slave),
        .out_if      (out_if.master)
`ifdef EX_WB_PIPE_STALL_CNT_EN
        ,
        .stall_cnt_o (stall_cnt_o),
        .full_o      (full_o)
`endif
    );

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d);
        in_if.valid     = v;
        in_if.int_res   = d;
        in_if.vec_res   = {4{d}};
        in_if.rd_int    = d[3:0];
        in_if.rd_vec    = d[5:4];
        in_if.wr_int    = 1'b1;
        in_if.wr_vec    = d[0];
        in_if.alu_flags = d[1:0];
    endtask

    task automatic test_reset();
        drive(1'b0, 16'h0);
        in_if.wr_int = 1'b0;
        out_if.ready = 1'b0;
        repeat (2) cyc();
        rst_i = 1'b1;
        cyc();
        total++; if (out_if.valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_if.valid); end
        total++; if (in_if.ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", in_if.ready); end
        total++; if (out_if.int_res !== 16'h0) begin bad++; $display("FAIL reset_int_res: got %h want 0", out_if.int_res); end
        total++; if (out_if.vec_res !== 64'h0) begin bad++; $display("FAIL reset_vec_res: got %h want 0", out_if.vec_res); end
        total++; if ({out_if.rd_int, out_if.rd_vec} !== 6'h0) begin bad++; $display("FAIL reset_rd: got %h want 0", {out_if.rd_int, out_if.rd_vec}); end
        total++; if ({out_if.wr_int, out_if.wr_vec, out_if.alu_flags} !== 4'h0) begin bad++; $display("FAIL reset_wr_flags: got %h want 0", {out_if.wr_int, out_if.wr_vec, out_if.alu_flags}); end
`ifdef EX_WB_PIPE_STALL_CNT_EN
        total++; if (stall_cnt_o !== 16'h0) begin bad++; $display("FAIL reset_stall_cnt: got %h want 0", stall_cnt_o); end
        total++; if (full_o !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", full_o); end
`endif
    endtask

    task automatic test_stream();
        out_if.ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 16'(i));
            cyc();
            total++; if (out_if.int_res !== 16'(i) || out_if.valid !== 1'b1) begin bad++; $display("FAIL stream_data[%0d]: got %h/%b want %h/1", i, out_if.int_res, out_if.valid, i); end
            total++; if (out_if.vec_res !== {4{16'(i)}}) begin bad++; $display("FAIL stream_vec[%0d]: got %h want %h", i, out_if.vec_res, {4{16'(i)}}); end
            total++; if (in_if.ready !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d]: got %b want 1", i, in_if.ready); end
        end
        drive(1'b0, 16'h0);
        cyc();
        total++; if (out_if.valid !== 1'b0 || out_if.wr_int !== 1'b0) begin bad++; $display("FAIL stream_drain: got valid=%b wr_int=%b want 0/0", out_if.valid, out_if.wr_int); end
    endtask

    task automatic test_skid();
        out_if.ready = 1'b0;
        drive(1'b1, 16'h00AA);
        cyc();
        total++; if (out_if.int_res !== 16'h00AA || in_if.ready !== 1'b1) begin bad++; $display("FAIL skid_busy: got %h ready=%b want 00aa ready=1", out_if.int_res, in_if.ready); end
        drive(1'b1, 16'h00BB);
        cyc();
        total++; if (out_if.int_res !== 16'h00AA || in_if.ready !== 1'b0) begin bad++; $display("FAIL skid_full: got %h ready=%b want 00aa ready=0", out_if.int_res, in_if.ready); end
`ifdef EX_WB_PIPE_STALL_CNT_EN
        total++; if (full_o !== 1'b1) begin bad++; $display("FAIL skid_full_o: got %b want 1", full_o); end
`endif
        drive(1'b1, 16'h00CC);
        cyc();
        total++; if (out_if.int_res !== 16'h00AA || out_if.valid !== 1'b1 || in_if.ready !== 1'b0) begin bad++; $display("FAIL skid_hold: got %h v=%b r=%b want 00aa v=1 r=0", out_if.int_res, out_if.valid, in_if.ready); end
        drive(1'b0, 16'h0);
        out_if.ready = 1'b1;
        cyc();
        total++; if (out_if.int_res !== 16'h00BB || out_if.valid !== 1'b1 || in_if.ready !== 1'b1) begin bad++; $display("FAIL skid_second: got %h v=%b r=%b want 00bb v=1 r=1", out_if.int_res, out_if.valid, in_if.ready); end
        cyc();
        total++; if (out_if.valid !== 1'b0) begin bad++; $display("FAIL skid_empty: got valid=%b want 0", out_if.valid); end
    endtask

    task automatic test_flush();
        out_if.ready = 1'b0;
        drive(1'b1, 16'h0011);
        cyc();
        drive(1'b1, 16'h0022);
        cyc();
        drive(1'b1, 16'h0033);
        flush_i = 1'b1;
        cyc();
        total++; if (out_if.valid !== 1'b0 || out_if.wr_int !== 1'b0 || in_if.ready !== 1'b1) begin bad++; $display("FAIL flush_full: got v=%b wr=%b r=%b want 0/0/1", out_if.valid, out_if.wr_int, in_if.ready); end
        // From BUSY, ready is high, so the flush must beat a real in-transfer.
        flush_i = 1'b0;
        drive(1'b1, 16'h0044);
        cyc();
        total++; if (out_if.int_res !== 16'h0044 || out_if.valid !== 1'b1) begin bad++; $display("FAIL flush_reload: got %h v=%b want 0044 v=1", out_if.int_res, out_if.valid); end
        drive(1'b1, 16'h0055);
        flush_i = 1'b1;
        cyc();
        total++; if (out_if.valid !== 1'b0 || out_if.wr_int !== 1'b0 || in_if.ready !== 1'b1) begin bad++; $display("FAIL flush_busy: got v=%b wr=%b r=%b want 0/0/1", out_if.valid, out_if.wr_int, in_if.ready); end
        flush_i = 1'b0;
        drive(1'b0, 16'h0);
        out_if.ready = 1'b1;
        repeat (2) begin
            cyc();
            total++; if (out_if.valid !== 1'b0) begin bad++; $display("FAIL flush_ghost: got valid=%b data=%h want 0", out_if.valid, out_if.int_res); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_q[$];
        logic [23:0] pat = 24'hB36D95;
        int          sent = 0;
        int          got  = 0;
        logic        in_fire, out_fire;
        for (int c = 0; c < 40 && got < 8; c++) begin
            drive(sent < 8, 16'h0100 + 16'(sent));
            out_if.ready = pat[c % 24];
            in_fire  = in_if.valid && in_if.ready;
            out_fire = out_if.valid && out_if.ready;
            if (out_fire) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL b2b_extra: got %h with nothing outstanding", out_if.int_res);
                end else begin
                    if (out_if.int_res !== exp_q[0]) begin bad++; $display("FAIL b2b_order[%0d]: got %h want %h", got, out_if.int_res, exp_q[0]); end
                    void'(exp_q.pop_front());
                end
                got++;
            end
            if (in_fire) begin
                exp_q.push_back(16'h0100 + 16'(sent));
                sent++;
            end
            cyc();
        end
        drive(1'b0, 16'h0);
        out_if.ready = 1'b1;
        total++; if (got != 8) begin bad++; $display("FAIL b2b_count: got %0d want 8", got); end
        cyc();
    endtask

    task automatic test_async_reset();
        out_if.ready = 1'b0;
        drive(1'b1, 16'h0066);
        cyc();
        drive(1'b1, 16'h0077);
        cyc();
        drive(1'b0, 16'h0);
        #2;
        rst_i = 1'b0;
        #1;
        total++; if (out_if.valid !== 1'b0 || in_if.ready !== 1'b1) begin bad++; $display("FAIL arst_handshake: got v=%b r=%b want 0/1", out_if.valid, in_if.ready); end
        total++; if (out_if.int_res !== 16'h0 || out_if.wr_int !== 1'b0 || out_if.alu_flags !== 2'b0) begin bad++; $display("FAIL arst_payload: got %h wr=%b f=%b want 0", out_if.int_res, out_if.wr_int, out_if.alu_flags); end
        cyc();
        rst_i = 1'b1;
        cyc();
    endtask

`ifdef EX_WB_PIPE_STALL_CNT_EN
    task automatic test_stall_cnt();
        out_if.ready = 1'b0;
        drive(1'b1, 16'h0099);
        cyc();
        drive(1'b0, 16'h0);
        repeat (70000) @(posedge clk_i);
        #1;
        total++; if (stall_cnt_o !== 16'hFFFF) begin bad++; $display("FAIL stall_sat: got %h want ffff", stall_cnt_o); end
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        cyc();
        total++; if (stall_cnt_o !== 16'hFFFF || out_if.valid !== 1'b0) begin bad++; $display("FAIL stall_flush: got %h v=%b want ffff v=0", stall_cnt_o, out_if.valid); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_back_to_back();
        test_async_reset();
`ifdef EX_WB_PIPE_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
